// File: rtl/vc_input_buffer.sv
// Purpose: per-input-port virtual-channel flit buffer; one circular FIFO per VC, credit return per popped flit.
// Latency: a write is visible at the head one cycle later. Credits and total_fill_o lag by one cycle. Other status is combinational.
// Backpressure: credit-based upstream; a write to a full VC is dropped unless that VC pops in the same cycle. Overflow and underflow set sticky flags.
module vc_input_buffer #(
    parameter int G_FLIT_SIZE       = 32,
    parameter int G_VCS             = 4,
    parameter int G_VC_BUFFER_DEPTH = 4,
    localparam int VCW = (G_VCS > 1) ? $clog2(G_VCS) : 1,
    localparam int PW  = (G_VC_BUFFER_DEPTH > 1) ? $clog2(G_VC_BUFFER_DEPTH) : 1,
    localparam int CW  = $clog2(G_VC_BUFFER_DEPTH + 1),
    localparam int TW  = $clog2(G_VCS * G_VC_BUFFER_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid_i,
    input  logic [VCW-1:0]               wr_vc_i,
    input  logic [G_FLIT_SIZE-1:0]       wr_flit_i,
    input  logic [G_VCS-1:0]             rd_en_i,
    output logic [G_VCS*G_FLIT_SIZE-1:0] head_flit_o,
    output logic [G_VCS-1:0]             vc_empty_o,
    output logic [G_VCS-1:0]             vc_full_o,
    output logic [G_VCS-1:0]             credit_o,
    output logic [G_VCS*CW-1:0]          fill_level_o,
    output logic [TW-1:0]                total_fill_o,
    output logic                         ovf_err_o,
    output logic                         udf_err_o
);

    // Flit storage is deliberately not reset; head content is meaningless while a VC is empty.
    logic [G_FLIT_SIZE-1:0] mem [G_VCS][G_VC_BUFFER_DEPTH];

    logic [G_VCS-1:0][PW-1:0] wr_ptr;
    logic [G_VCS-1:0][PW-1:0] rd_ptr;
    logic [G_VCS-1:0][CW-1:0] count;
    logic [G_VCS-1:0][CW-1:0] count_nxt;
    logic [G_VCS-1:0]         wr_hit;
    logic [G_VCS-1:0]         wr_ok;
    logic [G_VCS-1:0]         rd_ok;
    logic [G_VCS-1:0]         credit_q;
    logic [TW-1:0]            total_q;
    logic [TW-1:0]            total_sum;
    logic                     ovf_q;
    logic                     udf_q;
    logic                     ovf_now;
    logic                     udf_now;

    // Per-VC write/pop qualification, next occupancy and the sum of current occupancies.
    always_comb begin
        wr_hit    = '0;
        wr_ok     = '0;
        rd_ok     = '0;
        count_nxt = count;
        total_sum = '0;
        for (int v = 0; v < G_VCS; v++) begin
            wr_hit[v] = wr_valid_i && (wr_vc_i == VCW'(v));
            // No bypass: an empty VC cannot pop the flit arriving this cycle.
            rd_ok[v]  = rd_en_i[v] && (count[v] != '0);
            // A full VC still accepts a write when it pops in the same cycle.
            wr_ok[v]  = wr_hit[v] && ((count[v] != CW'(G_VC_BUFFER_DEPTH)) || rd_ok[v]);
            case ({wr_ok[v], rd_ok[v]})
                2'b10:   count_nxt[v] = count[v] + CW'(1);
                2'b01:   count_nxt[v] = count[v] - CW'(1);
                default: count_nxt[v] = count[v];
            endcase
            total_sum = total_sum + TW'(count[v]);
        end
        // An out-of-range VC number matches no VC and counts as a dropped write.
        ovf_now = wr_valid_i && ((wr_hit & ~wr_ok) != '0 || wr_hit == '0);
        udf_now = (rd_en_i & ~rd_ok) != '0;
    end

    // Pointers, occupancies, credit pulses, total fill and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            credit_q <= '0;
            total_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            for (int v = 0; v < G_VCS; v++) begin
                if (wr_ok[v]) begin
                    wr_ptr[v] <= (wr_ptr[v] == PW'(G_VC_BUFFER_DEPTH - 1)) ? '0 : wr_ptr[v] + PW'(1);
                end
                if (rd_ok[v]) begin
                    rd_ptr[v] <= (rd_ptr[v] == PW'(G_VC_BUFFER_DEPTH - 1)) ? '0 : rd_ptr[v] + PW'(1);
                end
            end
            count    <= count_nxt;
            credit_q <= rd_ok;
            total_q  <= total_sum;
            ovf_q    <= ovf_q | ovf_now;
            udf_q    <= udf_q | udf_now;
        end
    end

    // Flit storage write port; each VC writes at its own write pointer.
    always_ff @(posedge clk) begin
        for (int v = 0; v < G_VCS; v++) begin
            if (wr_ok[v]) begin
                mem[v][wr_ptr[v]] <= wr_flit_i;
            end
        end
    end

    // Head flits and per-VC status decoded from registered state.
    always_comb begin
        head_flit_o = '0;
        vc_empty_o  = '0;
        vc_full_o   = '0;
        for (int v = 0; v < G_VCS; v++) begin
            head_flit_o[v*G_FLIT_SIZE +: G_FLIT_SIZE] = mem[v][rd_ptr[v]];
            vc_empty_o[v] = (count[v] == '0);
            vc_full_o[v]  = (count[v] == CW'(G_VC_BUFFER_DEPTH));
        end
    end

    assign fill_level_o = count;
    assign total_fill_o = total_q;
    assign credit_o     = credit_q;
    assign ovf_err_o    = ovf_q;
    assign udf_err_o    = udf_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Purpose: directed checks of vc_input_buffer with hand-computed expectations.
// Latency: inputs are driven 1ns after a rising edge, and outputs are checked 1ns after the next rising edge.
// Backpressure: not applicable; the bench drives the link and pops directly.
module tb_vc_input_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid_i;
    logic [1:0]   wr_vc_i;
    logic [31:0]  wr_flit_i;
    logic [3:0]   rd_en_i;
    logic [127:0] head_flit_o;
    logic [3:0]   vc_empty_o;
    logic [3:0]   vc_full_o;
    logic [3:0]   credit_o;
    logic [11:0]  fill_level_o;
    logic [4:0]   total_fill_o;
    logic         ovf_err_o;
    logic         udf_err_o;

    int checks   = 0;
    int failures = 0;

    vc_input_buffer #(
        .G_FLIT_SIZE       (32),
        .G_VCS             (4),
        .G_VC_BUFFER_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid_i   (wr_valid_i),
        .wr_vc_i      (wr_vc_i),
        .wr_flit_i    (wr_flit_i),
        .rd_en_i      (rd_en_i),
        .head_flit_o  (head_flit_o),
        .vc_empty_o   (vc_empty_o),
        .vc_full_o    (vc_full_o),
        .credit_o     (credit_o),
        .fill_level_o (fill_level_o),
        .total_fill_o (total_fill_o),
        .ovf_err_o    (ovf_err_o),
        .udf_err_o    (udf_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid_i = 1'b0;
        wr_vc_i    = 2'd0;
        wr_flit_i  = 32'h0;
        rd_en_i    = 4'b0000;
    endtask

    task automatic wr(input logic [1:0] vc, input logic [31:0] flit);
        wr_valid_i = 1'b1;
        wr_vc_i    = vc;
        wr_flit_i  = flit;
    endtask

    function automatic logic [31:0] head(input int v);
        return head_flit_o[v*32 +: 32];
    endfunction

    function automatic logic [2:0] fill(input int v);
        return fill_level_o[v*3 +: 3];
    endfunction

    logic [31:0] pop_exp [4];

    initial begin
        // Reset
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty", vc_empty_o, 4'hF);
        chk("rst_full", vc_full_o, 4'h0);
        chk("rst_credit", credit_o, 4'h0);
        chk("rst_fill", fill_level_o, 12'h000);
        chk("rst_total", total_fill_o, 5'd0);
        chk("rst_ovf", ovf_err_o, 1'b0);
        chk("rst_udf", udf_err_o, 1'b0);

        // 1: fill VC2 with A0..A3
        wr(2'd2, 32'hA0);
        tick();
        chk("t1_head_first", head(2), 32'hA0);
        chk("t1_empty_first", vc_empty_o, 4'b1011);
        for (int i = 1; i < 4; i++) begin
            wr(2'd2, 32'hA0 + 32'(i));
            tick();
        end
        idle();
        chk("t1_full", vc_full_o, 4'b0100);
        chk("t1_fill2", fill(2), 3'd4);
        chk("t1_head", head(2), 32'hA0);
        chk("t1_total_lag", total_fill_o, 5'd3);
        tick();
        chk("t1_total", total_fill_o, 5'd4);

        // 2: write to full VC2 without pop is dropped
        wr(2'd2, 32'hFF);
        tick();
        idle();
        chk("t2_ovf", ovf_err_o, 1'b1);
        chk("t2_udf", udf_err_o, 1'b0);
        chk("t2_head", head(2), 32'hA0);
        chk("t2_fill2", fill(2), 3'd4);
        chk("t2_credit", credit_o, 4'h0);

        // 3: pop + write on full VC2, then drain across the pointer wrap
        wr(2'd2, 32'hB0);
        rd_en_i = 4'b0100;
        tick();
        idle();
        chk("t3_fill2", fill(2), 3'd4);
        chk("t3_full", vc_full_o, 4'b0100);
        chk("t3_credit", credit_o, 4'b0100);
        pop_exp[0] = 32'hA1;
        pop_exp[1] = 32'hA2;
        pop_exp[2] = 32'hA3;
        pop_exp[3] = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_pop%0d_head", i), head(2), pop_exp[i]);
            rd_en_i = 4'b0100;
            tick();
            chk($sformatf("t3_pop%0d_credit", i), credit_o, 4'b0100);
        end
        rd_en_i = 4'b0000;
        chk("t3_empty", vc_empty_o, 4'hF);
        chk("t3_fill2_end", fill(2), 3'd0);
        chk("t3_udf", udf_err_o, 1'b0);
        tick();
        chk("t3_credit_end", credit_o, 4'h0);

        // 4: write + pop on empty VC1 in the same cycle
        wr(2'd1, 32'h11);
        rd_en_i = 4'b0010;
        tick();
        idle();
        chk("t4_udf", udf_err_o, 1'b1);
        chk("t4_credit", credit_o, 4'h0);
        chk("t4_empty", vc_empty_o, 4'b1101);
        chk("t4_head1", head(1), 32'h11);
        chk("t4_fill1", fill(1), 3'd1);
        rd_en_i = 4'b0010;
        tick();
        idle();
        chk("t4_credit_pop", credit_o, 4'b0010);
        tick();

        // 5: one flit per VC, pop all at once
        for (int v = 0; v < 4; v++) begin
            wr(2'(v), 32'h50 + 32'(v));
            tick();
        end
        idle();
        tick();
        chk("t5_fill_all", fill_level_o, 12'h249);
        chk("t5_total", total_fill_o, 5'd4);
        chk("t5_head0", head(0), 32'h50);
        chk("t5_head3", head(3), 32'h53);
        rd_en_i = 4'b1111;
        tick();
        idle();
        chk("t5_credit", credit_o, 4'b1111);
        chk("t5_empty", vc_empty_o, 4'hF);
        chk("t5_fill_zero", fill_level_o, 12'h000);
        chk("t5_total_lag", total_fill_o, 5'd4);
        tick();
        chk("t5_total_zero", total_fill_o, 5'd0);
        chk("t5_credit_end", credit_o, 4'h0);

        // 6: reset mid-stream with VC3 holding 3 flits
        for (int i = 0; i < 3; i++) begin
            wr(2'd3, 32'h30 + 32'(i));
            tick();
        end
        idle();
        chk("t6_fill3", fill(3), 3'd3);
        rst = 1'b1;
        rd_en_i = 4'b1000;
        tick();
        rst = 1'b0;
        rd_en_i = 4'b0000;
        chk("t6_empty", vc_empty_o, 4'hF);
        chk("t6_fill", fill_level_o, 12'h000);
        chk("t6_total", total_fill_o, 5'd0);
        chk("t6_credit", credit_o, 4'h0);
        chk("t6_ovf", ovf_err_o, 1'b0);
        chk("t6_udf", udf_err_o, 1'b0);
        tick();
        chk("t6_credit_after", credit_o, 4'h0);
        chk("t6_total_after", total_fill_o, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
